// File: rtl/attack_phase_ctrl.sv
// Enemy attack-phase controller: spawns arrows toward the battle-box centre, resolves contacts
// as hits or shield blocks, and composites box and arrows. Define ATTACK_SHIELD_EN to enable blocking.
module attack_phase_ctrl #(
   parameter int unsigned N_ARROWS       = 8,
   parameter int unsigned SPAWN_INTERVAL = 30,
   parameter int unsigned ARROW_SPEED    = 2,
   parameter int unsigned START_DIST     = 64,
   parameter int unsigned SHIELD_R       = 16,
   parameter int unsigned ARROW_SIZE     = 8,
   parameter int unsigned BOX_X          = 432,
   parameter int unsigned BOX_Y          = 304,
   parameter int unsigned BOX_SIZE       = 160,
   parameter int unsigned BORDER         = 8,
   parameter int unsigned V_TICK         = 720,
   parameter logic [3:0]  START_STATE    = 4'b1000,
   parameter logic [11:0] FRAME_COLOR    = 12'hFFF,
   parameter logic [11:0] ARROW_COLOR    = 12'hF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [3:0]  state_in,
   input  logic [3:0]  turn_in,
   input  logic [1:0]  rotate_in,
   output logic        busy_out,
   output logic        finished_out,
   output logic        hit_out,
   output logic        block_out,
   output logic [4:0]  hit_count_out,
   output logic [11:0] pixel_out
);

   localparam logic [11:0] CX     = 12'(BOX_X + BOX_SIZE / 2);
   localparam logic [11:0] CY     = 12'(BOX_Y + BOX_SIZE / 2);
   localparam logic [11:0] BX0    = 12'(BOX_X);
   localparam logic [11:0] BX1    = 12'(BOX_X + BOX_SIZE);
   localparam logic [11:0] BXI0   = 12'(BOX_X + BORDER);
   localparam logic [11:0] BXI1   = 12'(BOX_X + BOX_SIZE - BORDER);
   localparam logic [11:0] BY0    = 12'(BOX_Y);
   localparam logic [11:0] BY1    = 12'(BOX_Y + BOX_SIZE);
   localparam logic [11:0] BYI0   = 12'(BOX_Y + BORDER);
   localparam logic [11:0] BYI1   = 12'(BOX_Y + BOX_SIZE - BORDER);
   localparam logic [11:0] DIST0  = 12'(START_DIST);
   localparam logic [11:0] STEP   = 12'(ARROW_SPEED);
   localparam logic [11:0] RES_TH = 12'(SHIELD_R + ARROW_SPEED);
   localparam logic [11:0] ASZ    = 12'(ARROW_SIZE);
   localparam logic [11:0] AHALF  = 12'(ARROW_SIZE / 2);
   localparam int unsigned CW     = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(SPAWN_INTERVAL - 1);
   localparam logic [4:0]  N_LAST = 5'(N_ARROWS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              state_q;
   logic [3:0]          turn_q;
   logic [4:0]          spawned_q;
   logic [CW-1:0]       spawn_cnt_q;
   logic                armed_q;
   logic [N_ARROWS-1:0] active_q;
   logic [11:0]         dist_q [N_ARROWS];
   logic [1:0]          dir_q  [N_ARROWS];

   logic                tick, start, moving, spawn_now, busy_nxt;
   logic                any_hit, any_block, arrow_hit, in_outer, in_inner;
   logic [3:0]          dir_mul;
   logic [1:0]          dir_new;
   logic [N_ARROWS-1:0] resolve, blocked;
   logic [11:0]         h12, v12, pix;

   // Arrow square for one slot; the near edge sits at dist from the centre.
   function automatic logic arrow_at(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] d, input logic [1:0] dir);
      logic on_v, on_h;
      on_v = (x >= CX - AHALF) && (x < CX - AHALF + ASZ);
      on_h = (y >= CY - AHALF) && (y < CY - AHALF + ASZ);
      case (dir)
         2'd0:    arrow_at = on_v && (y >= CY - d - ASZ) && (y < CY - d);
         2'd1:    arrow_at = on_h && (x >= CX + d) && (x < CX + d + ASZ);
         2'd2:    arrow_at = on_v && (y >= CY + d) && (y < CY + d + ASZ);
         default: arrow_at = on_h && (x >= CX - d - ASZ) && (x < CX - d);
      endcase
   endfunction

`ifndef ATTACK_SHIELD_EN
   logic unused_rotate;
   assign unused_rotate = ^rotate_in;
`endif

   always_comb begin
      tick      = (hcount_in == 11'd0) && (vcount_in == 10'(V_TICK));
      start     = (state_q == StIdle) && (state_in == START_STATE) && armed_q;
      moving    = tick && ((state_q == StRun) || (state_q == StDrain));
      spawn_now = tick && (state_q == StRun) && (spawn_cnt_q == '0);
      dir_mul   = {2'b00, spawned_q[1:0]} * {2'b00, turn_q[1:0] | 2'b01};
      dir_new   = dir_mul[1:0] + turn_q[3:2];

      any_hit   = 1'b0;
      any_block = 1'b0;
      resolve   = '0;
      blocked   = '0;
      for (int i = 0; i < int'(N_ARROWS); i++) begin
         resolve[i] = moving && active_q[i] && (dist_q[i] <= RES_TH);
`ifdef ATTACK_SHIELD_EN
         blocked[i] = (rotate_in == dir_q[i]);
`else
         blocked[i] = 1'b0;
`endif
         if (resolve[i]) begin
            if (blocked[i]) any_block = 1'b1;
            else            any_hit   = 1'b1;
         end
      end

      case (state_q)
         StIdle:  busy_nxt = start;
         StRun:   busy_nxt = 1'b1;
         StDrain: busy_nxt = |active_q;
         default: busy_nxt = 1'b0;
      endcase

      h12       = {1'b0, hcount_in};
      v12       = {2'b00, vcount_in};
      in_outer  = (h12 >= BX0) && (h12 < BX1) && (v12 >= BY0) && (v12 < BY1);
      in_inner  = (h12 >= BXI0) && (h12 < BXI1) && (v12 >= BYI0) && (v12 < BYI1);
      arrow_hit = 1'b0;
      for (int i = 0; i < int'(N_ARROWS); i++) begin
         if (active_q[i] && arrow_at(h12, v12, dist_q[i], dir_q[i])) arrow_hit = 1'b1;
      end
      if (arrow_hit)                 pix = ARROW_COLOR;
      else if (in_outer && !in_inner) pix = FRAME_COLOR;
      else                           pix = 12'h000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         turn_q        <= 4'd0;
         spawned_q     <= 5'd0;
         spawn_cnt_q   <= '0;
         armed_q       <= 1'b1;
         active_q      <= '0;
         busy_out      <= 1'b0;
         finished_out  <= 1'b0;
         hit_out       <= 1'b0;
         block_out     <= 1'b0;
         hit_count_out <= 5'd0;
         pixel_out     <= 12'h000;
         for (int i = 0; i < int'(N_ARROWS); i++) begin
            dist_q[i] <= 12'd0;
            dir_q[i]  <= 2'd0;
         end
      end else begin
         finished_out <= 1'b0;
         hit_out      <= any_hit;
         block_out    <= any_block;
         // Gate on next-cycle busy so pixel_out is never non-zero while busy_out is low.
         pixel_out    <= busy_nxt ? pix : 12'h000;
         if (state_in != START_STATE) armed_q <= 1'b1;
         if (any_hit && (hit_count_out != 5'd31)) hit_count_out <= hit_count_out + 5'd1;

         for (int i = 0; i < int'(N_ARROWS); i++) begin
            if (resolve[i]) begin
               active_q[i] <= 1'b0;
            end else if (moving && active_q[i]) begin
               dist_q[i] <= dist_q[i] - STEP;
            end else if (spawn_now && (5'(i) == spawned_q)) begin
               active_q[i] <= 1'b1;
               dist_q[i]   <= DIST0;
               dir_q[i]    <= dir_new;
            end
         end

         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q       <= StRun;
                  busy_out      <= 1'b1;
                  turn_q        <= turn_in;
                  hit_count_out <= 5'd0;
                  spawned_q     <= 5'd0;
                  spawn_cnt_q   <= '0;
                  armed_q       <= 1'b0;
               end
            end
            StRun: begin
               if (tick) begin
                  if (spawn_cnt_q == '0) begin
                     spawned_q   <= spawned_q + 5'd1;
                     spawn_cnt_q <= CNT_RELOAD;
                     if (spawned_q == N_LAST) state_q <= StDrain;
                  end else begin
                     spawn_cnt_q <= spawn_cnt_q - CW'(1);
                  end
               end
            end
            StDrain: begin
               if (active_q == '0) begin
                  state_q      <= StDone;
                  busy_out     <= 1'b0;
                  finished_out <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_attack_phase_ctrl.sv
// Directed bench for attack_phase_ctrl; block expectations follow ATTACK_SHIELD_EN.
module tb_attack_phase_ctrl;

   localparam logic [11:0] FRAME = 12'hFFF;
   localparam logic [11:0] ARROW = 12'hF00;
`ifdef ATTACK_SHIELD_EN
   localparam bit SHIELD = 1'b1;
`else
   localparam bit SHIELD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  state_in, turn;
   logic [1:0]  rotate;
   logic        busy, finished, hit, block;
   logic [4:0]  hit_count;
   logic [11:0] pixel;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   attack_phase_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .hcount_in     (hcount),
      .vcount_in     (vcount),
      .state_in      (state_in),
      .turn_in       (turn),
      .rotate_in     (rotate),
      .busy_out      (busy),
      .finished_out  (finished),
      .hit_out       (hit),
      .block_out     (block),
      .hit_count_out (hit_count),
      .pixel_out     (pixel)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int dir_of(input int m, input logic [3:0] t);
      return (m * int'(t[1:0] | 2'b01) + int'(t[3:2])) % 4;
   endfunction

   // One frame tick, then one ordinary cycle; returns the pulses seen after each.
   task automatic do_tick(output logic h, output logic b, output logic f);
      hcount = 11'd0;
      vcount = 10'd720;
      step();
      h = hit;
      b = block;
      hcount = 11'd100;
      vcount = 10'd0;
      step();
      f = finished;
   endtask

   // Slot m resolves on tick 24+30m; the phase ends after tick 234.
   task automatic run_phase(input logic [3:0] t_in, input bit avoid, input logic [1:0] rot_const,
                            input int abort_at, input bit pix_chk);
      logic h, b, f;
      int   spurious, exp_hits, m;
      bit   exp_blk;
      spurious = 0;
      exp_hits = 0;
      turn     = t_in;
      state_in = 4'd8;
      step();
      check_eq("busy_rise", busy, 1);
      for (int t = 0; t <= 234; t++) begin
         m      = (t >= 24) ? (t - 24) / 30 : 0;
         rotate = avoid ? 2'((dir_of(m, t_in) + 2) % 4) : rot_const;
         do_tick(h, b, f);
         if (t >= 24 && (t - 24) % 30 == 0) begin
            exp_blk = SHIELD && (rotate == 2'(dir_of(m, t_in)));
            if (!exp_blk) exp_hits++;
            check_eq("hit_pulse", h, !exp_blk);
            check_eq("block_pulse", b, exp_blk);
         end else if (h || b) begin
            spurious++;
         end
         if (t == 0) check_eq("busy_run", busy, 1);
         if (t == 0 && pix_chk) begin
            hcount = 11'd512; vcount = 10'd316; step();
            check_eq("pix_arrow", pixel, ARROW);
            hcount = 11'd432; vcount = 10'd304; step();
            check_eq("pix_frame_corner", pixel, FRAME);
            hcount = 11'd512; vcount = 10'd311; step();
            check_eq("pix_above_arrow", pixel, FRAME);
            hcount = 11'd512; vcount = 10'd320; step();
            check_eq("pix_inside", pixel, 0);
            hcount = 11'd100; vcount = 10'd0;
         end
         if (t == abort_at) begin
            hcount = 11'd432; vcount = 10'd304; rst = 1'b1;
            step();
            rst = 1'b0;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_pixel", pixel, 0);
            check_eq("rst_finished", finished, 0);
            check_eq("rst_hit_count", hit_count, 0);
            hcount = 11'd100; vcount = 10'd0;
            return;
         end
         if (t < 234 && f) spurious++;
         if (t == 234) begin
            check_eq("finished", f, 1);
            check_eq("busy_done", busy, 0);
         end
      end
      check_eq("spurious_pulses", spurious, 0);
      check_eq("hit_count", hit_count, exp_hits);
      step();
      check_eq("finished_one_cycle", finished, 0);
   endtask

   initial begin
      logic h, b, f;
      rst      = 1'b1;
      hcount   = 11'd100;
      vcount   = 10'd0;
      state_in = 4'd0;
      turn     = 4'd0;
      rotate   = 2'd0;
      step();
      step();
      check_eq("reset_busy", busy, 0);
      check_eq("reset_finished", finished, 0);
      check_eq("reset_hit", hit, 0);
      check_eq("reset_block", block, 0);
      check_eq("reset_hit_count", hit_count, 0);
      check_eq("reset_pixel", pixel, 0);
      rst = 1'b0;
      step();
      check_eq("idle_busy", busy, 0);

      // turn 0, shield always facing away
      run_phase(4'd0, 1'b1, 2'd0, -1, 1'b1);
      hcount = 11'd432; vcount = 10'd304; step();
      check_eq("pix_idle", pixel, 0);

      // start level still held: must not re-arm
      hcount = 11'd100; vcount = 10'd0;
      repeat (3) step();
      do_tick(h, b, f);
      check_eq("no_restart", busy, 0);

      // turn 0101, rotate held at 2
      state_in = 4'd0; step();
      run_phase(4'b0101, 1'b0, 2'd2, -1, 1'b0);

      // aborted phase, then a fresh one
      state_in = 4'd0; step();
      run_phase(4'd0, 1'b1, 2'd0, 100, 1'b0);
      run_phase(4'd0, 1'b1, 2'd0, -1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
